valu_pipe: RTL
==============

VALU_PIPE -- requirements
Module: valu_pipe

Interface
Parameters
- REQ-001: ELEM_W, default 32, element width in bits; legal values 8, 16, 32, 64.
- REQ-002: LANES, default 4, number of parallel element lanes; legal range 1 to 16.
- REQ-003: TAG_W, default 4, width of the opaque tag carried alongside each operation.

Ports (W = ELEM_W*LANES)
- REQ-004: clk_i  in  1  single clock; all state updates on rising edge.
- REQ-005: rst_ni  in  1  asynchronous, active-low reset.
- REQ-006: in_valid_i  in  1  input operation valid.
- REQ-007: in_ready_o  out  1  block accepts the input operation this cycle.
- REQ-008: alu_op_i  in  4  operation code; 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU.
- REQ-009: rs1_i  in  W  source-1 vector; lane k = bits [k*ELEM_W +: ELEM_W].
- REQ-010: rs2_i  in  W  source-2 vector, same lane packing.
- REQ-011: mask_i  in  LANES  per-lane enable; 1 = active.
- REQ-012: tag_i  in  TAG_W  tag, returned unchanged with the result.
- REQ-013: out_valid_o  out  1  result valid.
- REQ-014: out_ready_i  in  1  consumer accepts the result.
- REQ-015: res_o  out  W  result vector.
- REQ-016: tag_o  out  TAG_W  tag of the result.
- REQ-017: zero_o / neg_o / ovf_o  out  LANES each  per-lane flags.
- REQ-018: all_zero_o  out  1  every active lane result is zero.

Function
- REQ-019: Two register stages, S1 (operand capture) and S2 (result); each stage holds a valid bit.
- REQ-020: S2 advances when !s2_valid || out_ready_i; S1 advances when S2 advances; in_ready_o = !s1_valid || S2 advances.
- REQ-021: An input is accepted on a rising edge with in_valid_i && in_ready_o; with no backpressure, the result is presented on out_valid_o exactly 2 cycles after acceptance.
- REQ-022: A throughput of one operation per cycle is sustained while out_ready_i is held high.
- REQ-023: While out_valid_o && !out_ready_i, res_o, tag_o, and all flags hold stable, and no accepted operation is dropped or duplicated.
- REQ-024: Operations complete in order; tags leave in acceptance order.
- REQ-025: ADD and SUB wrap modulo 2^ELEM_W per lane; no carry propagates across lanes.
- REQ-026: Shift amount is the low log2(ELEM_W) bits of the rs2 lane; SRA replicates the lane MSB.
- REQ-027: SLT, SLTU, and all compare ops (10-15) produce 1 or 0 in the lane LSB and zeros above; LT and SLT are signed; LTU and SLTU are unsigned.
- REQ-028: For inactive lanes (mask bit 0), the result lane equals the rs1 lane unchanged, and zero_o, neg_o, and ovf_o for that lane are 0.
- REQ-029: zero_o[k] = active && result lane == 0; neg_o[k] = active && result lane MSB.
- REQ-030: ovf_o[k] = active && signed overflow, for ADD and SUB only; it is 0 for all other ops.
- REQ-031: all_zero_o = AND over active lanes of zero-result; it is 1 when mask_i is all zero.
- REQ-032: Simultaneous accept at the input and drain at the output in the same cycle is legal and loses no data.

Reset
- REQ-033: While rst_ni = 0: s1_valid, s2_valid, and out_valid_o = 0; in_ready_o = 1; res_o, tag_o, all flags, and all_zero_o = 0.
- REQ-034: Reset asserted mid-operation discards all in-flight operations; no result emerges after reset is released.
- REQ-035: The first acceptance is possible on the first rising edge after rst_ni deasserts.

Verification (defaults ELEM_W=32, LANES=4)
- REQ-036: ADD, rs1 lanes {5,7,0x7FFFFFFF,0xFFFFFFFF}, rs2 lanes {3,-7,1,1}, mask 4'b1111, tag 3 -> after 2 cycles res {8,0,0x80000000,0}, zero_o 4'b1010, neg_o 4'b0100, ovf_o 4'b0100, all_zero_o 0, tag_o 3.
- REQ-037: SRA, rs1 all lanes 0xFFFFFFF0, rs2 lanes {2,0,31,33}, mask 4'b1111 -> res {0xFFFFFFFC,0xFFFFFFF0,0xFFFFFFFF,0xFFFFFFF8}.
- REQ-038: LT, rs1 {3,-1,5,5}, rs2 {5,1,3,5}, mask 4'b0011 -> res {1,1,5,5}, zero_o 0, all_zero_o 0.
- REQ-039: Stream 6 ops with tags 0-5 back to back and out_ready_i low for cycles 3-6 -> in_ready_o drops once S1 and S2 are both full; tags emerge 0..5 in order with none lost; outputs are stable while stalled.
- REQ-040: Assert rst_ni low with 2 ops in flight -> out_valid_o = 0 immediately; after release, no stale result appears; a new op completes in 2 cycles.
- REQ-041: Repeat REQ-036 lane patterns at ELEM_W=8, LANES=8 -> lane-isolated wraparound with no carry between lanes.

Source files
------------

// File: rtl/valu_pipe.sv
// rtl/valu_pipe.sv - two-stage masked vector ALU pipeline with per-lane flags
module valu_pipe #(
  parameter int ELEM_W = 32,
  parameter int LANES  = 4,
  parameter int TAG_W  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [3:0]              alu_op_i,
  input  logic [ELEM_W*LANES-1:0] rs1_i,
  input  logic [ELEM_W*LANES-1:0] rs2_i,
  input  logic [LANES-1:0]        mask_i,
  input  logic [TAG_W-1:0]        tag_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [ELEM_W*LANES-1:0] res_o,
  output logic [TAG_W-1:0]        tag_o,
  output logic [LANES-1:0]        zero_o,
  output logic [LANES-1:0]        neg_o,
  output logic [LANES-1:0]        ovf_o,
  output logic                    all_zero_o
);

  localparam int W    = ELEM_W * LANES;
  localparam int SH_W = $clog2(ELEM_W);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_EQ   = 4'd10,
    OP_NE   = 4'd11,
    OP_LT   = 4'd12,
    OP_GE   = 4'd13,
    OP_LTU  = 4'd14,
    OP_GEU  = 4'd15
  } alu_op_e;

  // Stage 1: captured operands
  logic            s1_valid_q, s1_valid_d;
  alu_op_e         s1_op_q, s1_op_d;
  logic [W-1:0]    s1_rs1_q, s1_rs1_d;
  logic [W-1:0]    s1_rs2_q, s1_rs2_d;
  logic [LANES-1:0] s1_mask_q, s1_mask_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  // Stage 2: registered result and flags
  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     s2_res_q, s2_res_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic [LANES-1:0] s2_zero_q, s2_zero_d;
  logic [LANES-1:0] s2_neg_q, s2_neg_d;
  logic [LANES-1:0] s2_ovf_q, s2_ovf_d;
  logic             s2_all_zero_q, s2_all_zero_d;

  // Combinational lane results computed from stage 1
  logic [W-1:0]     calc_res;
  logic [LANES-1:0] calc_zero;
  logic [LANES-1:0] calc_neg;
  logic [LANES-1:0] calc_ovf;
  logic             calc_all_zero;
  logic             a_msb, b_msb, r_msb;

  logic s2_adv;

  // Widen a compare outcome into a lane holding 0 or 1
  function automatic logic [ELEM_W-1:0] bit_to_lane(input logic b);
    bit_to_lane = {{(ELEM_W-1){1'b0}}, b};
  endfunction

  // One lane of the ALU; shifts use only the low log2(ELEM_W) bits of b
  function automatic logic [ELEM_W-1:0] lane_alu(input alu_op_e op,
                                                 input logic [ELEM_W-1:0] a,
                                                 input logic [ELEM_W-1:0] b);
    logic [SH_W-1:0] sh;
    logic            lt_s;
    logic            lt_u;
    logic            eq;
    sh   = b[SH_W-1:0];
    lt_s = $signed(a) < $signed(b);
    lt_u = a < b;
    eq   = (a == b);
    case (op)
      OP_ADD:          lane_alu = a + b;
      OP_SUB:          lane_alu = a - b;
      OP_SLL:          lane_alu = a << sh;
      OP_SLT, OP_LT:   lane_alu = bit_to_lane(lt_s);
      OP_SLTU, OP_LTU: lane_alu = bit_to_lane(lt_u);
      OP_XOR:          lane_alu = a ^ b;
      OP_SRL:          lane_alu = a >> sh;
      OP_SRA:          lane_alu = $signed(a) >>> sh;
      OP_OR:           lane_alu = a | b;
      OP_AND:          lane_alu = a & b;
      OP_EQ:           lane_alu = bit_to_lane(eq);
      OP_NE:           lane_alu = bit_to_lane(!eq);
      OP_GE:           lane_alu = bit_to_lane(!lt_s);
      OP_GEU:          lane_alu = bit_to_lane(!lt_u);
      default:         lane_alu = '0;
    endcase
  endfunction

  // Pipeline handshake: S1 can only move when S2 moves, so one shared advance
  assign s2_adv     = !s2_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s2_adv;

  // Per-lane results and flags; inactive lanes pass rs1 through with flags cleared
  always_comb begin
    calc_res      = '0;
    calc_zero     = '0;
    calc_neg      = '0;
    calc_ovf      = '0;
    calc_all_zero = 1'b1;
    a_msb         = 1'b0;
    b_msb         = 1'b0;
    r_msb         = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (s1_mask_q[k]) begin
        calc_res[k*ELEM_W +: ELEM_W] = lane_alu(s1_op_q,
                                                s1_rs1_q[k*ELEM_W +: ELEM_W],
                                                s1_rs2_q[k*ELEM_W +: ELEM_W]);
        a_msb        = s1_rs1_q[k*ELEM_W + ELEM_W - 1];
        b_msb        = s1_rs2_q[k*ELEM_W + ELEM_W - 1];
        r_msb        = calc_res[k*ELEM_W + ELEM_W - 1];
        calc_zero[k] = (calc_res[k*ELEM_W +: ELEM_W] == '0);
        calc_neg[k]  = r_msb;
        case (s1_op_q)
          OP_ADD:  calc_ovf[k] = (a_msb == b_msb) && (r_msb != a_msb);
          OP_SUB:  calc_ovf[k] = (a_msb != b_msb) && (r_msb != a_msb);
          default: calc_ovf[k] = 1'b0;
        endcase
      end else begin
        calc_res[k*ELEM_W +: ELEM_W] = s1_rs1_q[k*ELEM_W +: ELEM_W];
      end
      calc_all_zero = calc_all_zero & (!s1_mask_q[k] || calc_zero[k]);
    end
  end

  // Stage 1 next state: load a new operation whenever the slot is free or draining
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_rs1_d   = s1_rs1_q;
    s1_rs2_d   = s1_rs2_q;
    s1_mask_d  = s1_mask_q;
    s1_tag_d   = s1_tag_q;
    if (in_ready_o) begin
      s1_valid_d = in_valid_i;
      if (in_valid_i) begin
        s1_op_d   = alu_op_e'(alu_op_i);
        s1_rs1_d  = rs1_i;
        s1_rs2_d  = rs2_i;
        s1_mask_d = mask_i;
        s1_tag_d  = tag_i;
      end
    end
  end

  // Stage 2 next state: hold while stalled so outputs stay stable under backpressure
  always_comb begin
    s2_valid_d    = s2_valid_q;
    s2_res_d      = s2_res_q;
    s2_tag_d      = s2_tag_q;
    s2_zero_d     = s2_zero_q;
    s2_neg_d      = s2_neg_q;
    s2_ovf_d      = s2_ovf_q;
    s2_all_zero_d = s2_all_zero_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d      = calc_res;
        s2_tag_d      = s1_tag_q;
        s2_zero_d     = calc_zero;
        s2_neg_d      = calc_neg;
        s2_ovf_d      = calc_ovf;
        s2_all_zero_d = calc_all_zero;
      end
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_ADD;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_mask_q  <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_rs1_q   <= s1_rs1_d;
      s1_rs2_q   <= s1_rs2_d;
      s1_mask_q  <= s1_mask_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  // Stage 2 registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q    <= 1'b0;
      s2_res_q      <= '0;
      s2_tag_q      <= '0;
      s2_zero_q     <= '0;
      s2_neg_q      <= '0;
      s2_ovf_q      <= '0;
      s2_all_zero_q <= 1'b0;
    end else begin
      s2_valid_q    <= s2_valid_d;
      s2_res_q      <= s2_res_d;
      s2_tag_q      <= s2_tag_d;
      s2_zero_q     <= s2_zero_d;
      s2_neg_q      <= s2_neg_d;
      s2_ovf_q      <= s2_ovf_d;
      s2_all_zero_q <= s2_all_zero_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign res_o       = s2_res_q;
  assign tag_o       = s2_tag_q;
  assign zero_o      = s2_zero_q;
  assign neg_o       = s2_neg_q;
  assign ovf_o       = s2_ovf_q;
  assign all_zero_o  = s2_all_zero_q;

endmodule
